sqrt_sched: RTL and testbench

- Shares one square-root engine among NUM_REQ requesters. The engine takes a one-cycle IN_VALID pulse with a 16-bit radicand and returns a 12-bit rounded 8.4 fixed-point root on a one-cycle OUT_VALID pulse a fixed number of cycles later.
- Round-robin arbitration; one operation in flight at a time; results returned through a single response channel tagged with the requester ID.
- Sits between the requester fabric and the SQRT datapath instance.

---
 rtl/sqrt_sched_pkg.sv | 14 +
 rtl/sqrt_sched_if.sv | 27 ++
 rtl/sqrt_sched_rr_arbiter.sv | 30 +++
 rtl/sqrt_sched.sv | 142 ++++++++++++++
 tb/tb_sqrt_sched.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sqrt_sched_pkg.sv
// Shared types and widths for the square-root request scheduler.
package sqrt_sched_pkg;

  localparam int unsigned SQRT_IN_W  = 16;
  localparam int unsigned SQRT_OUT_W = 12;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StResp
  } state_e;

endpackage

// File: rtl/sqrt_sched_if.sv
// Requester fabric <-> scheduler bundle: per-port requests and the tagged response channel.
interface sqrt_sched_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
);
  import sqrt_sched_pkg::*;

  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ*SQRT_IN_W-1:0] req_data;
  logic [NUM_REQ-1:0]           req_ready;
  logic                         rsp_valid;
  logic                         rsp_ready;
  logic [ID_W-1:0]              rsp_id;
  logic [SQRT_OUT_W-1:0]        rsp_data;
  logic                         rsp_err;

  modport master (
    output req_valid, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
  );

endinterface

// File: rtl/sqrt_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or above ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id,
  output logic               any
);

  logic [ID_W-1:0] idx;

  always_comb begin
    grant    = '0;
    grant_id = '0;
    any      = 1'b0;
    idx      = '0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      idx = ID_W'((32'(ptr) + off) % NUM_REQ);
      if (!any && req[idx]) begin
        grant[idx] = 1'b1;
        grant_id   = idx;
        any        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sqrt_sched.sv
// Shares one square-root engine among NUM_REQ requesters, one operation in flight.
// Optional wait-timeout abort is enabled by defining SQRT_SCHED_TIMEOUT_EN.
module sqrt_sched
  import sqrt_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2,
  parameter int unsigned TIMEOUT = 32
) (
  input  logic                  CLK,
  input  logic                  RST,
  sqrt_sched_if.slave           bus,
  output logic                  sqrt_in_valid,
  output logic [SQRT_IN_W-1:0]  sqrt_in,
  input  logic                  sqrt_out_valid,
  input  logic [SQRT_OUT_W-1:0] sqrt_out
);

  state_e                state_q, state_d;
  logic [ID_W-1:0]       ptr_q, ptr_d;
  logic [ID_W-1:0]       id_q, id_d;
  logic [SQRT_IN_W-1:0]  data_q, data_d;
  logic [SQRT_OUT_W-1:0] res_q, res_d;

  logic [NUM_REQ-1:0]   grant;
  logic [ID_W-1:0]      grant_id;
  logic                 grant_any;
  logic [SQRT_IN_W-1:0] slice [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
    assign slice[i] = bus.req_data[SQRT_IN_W*i +: SQRT_IN_W];
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req      (bus.req_valid),
    .ptr      (ptr_q),
    .grant    (grant),
    .grant_id (grant_id),
    .any      (grant_any)
  );

`ifdef SQRT_SCHED_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;
  assign bus.rsp_err = err_q;
`else
  assign bus.rsp_err = 1'b0;
`endif

  assign bus.rsp_id   = id_q;
  assign bus.rsp_data = res_q;

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    id_d          = id_q;
    data_d        = data_q;
    res_d         = res_q;
    bus.req_ready = '0;
    bus.rsp_valid = 1'b0;
    sqrt_in_valid = 1'b0;
    sqrt_in       = '0;
`ifdef SQRT_SCHED_TIMEOUT_EN
    cnt_d         = cnt_q;
    err_d         = err_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (grant_any) begin
          bus.req_ready = grant;
          id_d          = grant_id;
          data_d        = slice[grant_id];
          state_d       = StIssue;
`ifdef SQRT_SCHED_TIMEOUT_EN
          err_d         = 1'b0;
`endif
        end
      end
      StIssue: begin
        sqrt_in_valid = 1'b1;
        sqrt_in       = data_q;
        state_d       = StWait;
`ifdef SQRT_SCHED_TIMEOUT_EN
        cnt_d         = '0;
`endif
      end
      StWait: begin
        // A result arriving on the expiry cycle takes priority over the abort.
        if (sqrt_out_valid) begin
          res_d   = sqrt_out;
          state_d = StResp;
`ifdef SQRT_SCHED_TIMEOUT_EN
          err_d   = 1'b0;
        end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
          res_d   = '0;
          err_d   = 1'b1;
          state_d = StResp;
        end else begin
          cnt_d   = cnt_q + 1'b1;
`endif
        end
      end
      StResp: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) begin
          ptr_d   = (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      id_q    <= '0;
      data_q  <= '0;
      res_q   <= '0;
`ifdef SQRT_SCHED_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      data_q  <= data_d;
      res_q   <= res_d;
`ifdef SQRT_SCHED_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_sqrt_sched.sv
// Directed bench for sqrt_sched with a 14-cycle behavioural engine and a response scoreboard.
module tb_sqrt_sched;
  import sqrt_sched_pkg::*;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned ID_W    = 2;
  localparam int unsigned TIMEOUT = 32;
  localparam int          LAT     = 14;

  logic        CLK = 1'b0;
  logic        RST;
  logic        sqrt_in_valid;
  logic [15:0] sqrt_in;
  logic        sqrt_out_valid;
  logic [11:0] sqrt_out;

  sqrt_sched_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

  sqrt_sched #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .CLK            (CLK),
    .RST            (RST),
    .bus            (bus),
    .sqrt_in_valid  (sqrt_in_valid),
    .sqrt_in        (sqrt_in),
    .sqrt_out_valid (sqrt_out_valid),
    .sqrt_out       (sqrt_out)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic            err;
    logic [ID_W-1:0] id;
    logic [11:0]     data;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Rounded 8.4 root: round(sqrt(x * 256)), saturated to 12 bits.
  function automatic logic [11:0] root84(input logic [15:0] x);
    longint unsigned v, r;
    v = longint'(x) << 8;
    r = 0;
    while ((r + 1) * (r + 1) <= v) r++;
    if (v - r * r > r) r++;
    if (r > 4095) r = 4095;
    return 12'(r);
  endfunction

  // Engine model
  bit          model_on   = 1'b1;
  int          mdl_cnt    = 0;
  logic [11:0] mdl_val    = '0;
  logic        mdl_valid  = 1'b0;
  logic [11:0] mdl_data   = '0;
  logic        spur_valid = 1'b0;
  logic [11:0] spur_data  = '0;

  assign sqrt_out_valid = mdl_valid | spur_valid;
  assign sqrt_out       = spur_valid ? spur_data : mdl_data;

  always @(posedge CLK) begin
    mdl_valid <= 1'b0;
    if (sqrt_in_valid && model_on) begin
      mdl_cnt <= LAT;
      mdl_val <= root84(sqrt_in);
    end else if (mdl_cnt != 0) begin
      mdl_cnt <= mdl_cnt - 1;
      if (mdl_cnt == 1) begin
        mdl_valid <= 1'b1;
        mdl_data  <= mdl_val;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_vec++;
    assert (obs === want) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge CLK);
  endtask

  task automatic set_req(input int p, input logic [15:0] d);
    bus.req_valid[p]          = 1'b1;
    bus.req_data[16*p +: 16]  = d;
  endtask

  // Waits for the grant, checks it and the following ISSUE cycle; returns at the ISSUE negedge.
  task automatic grant(input int p, input logic [15:0] d);
    int t = 0;
    #1;
    while (bus.req_ready == '0 && t < 50) begin
      tick();
      #1;
      t++;
    end
    chk("grant_onehot", 32'(bus.req_ready), 32'(1) << p);
    sb.push_back('{err: 1'b0, id: ID_W'(p), data: root84(d)});
    tick();
    bus.req_valid[p] = 1'b0;
    chk("issue_valid", 32'(sqrt_in_valid), 1);
    chk("issue_data", 32'(sqrt_in), 32'(d));
    chk("no_ready_in_issue", 32'(bus.req_ready), 0);
  endtask

  task automatic wait_rsp(input int budget);
    int   t = 0;
    exp_t e;
    while (!bus.rsp_valid && t < budget) begin
      tick();
      t++;
    end
    chk("rsp_seen", 32'(bus.rsp_valid), 1);
    if (bus.rsp_valid) begin
      if (sb.size() != 0) e = sb.pop_front();
      else e = '1;
      chk("rsp_id", 32'(bus.rsp_id), 32'(e.id));
      chk("rsp_data", 32'(bus.rsp_data), 32'(e.data));
      chk("rsp_err", 32'(bus.rsp_err), 32'(e.err));
      bus.rsp_ready = 1'b1;
      tick();
      bus.rsp_ready = 1'b0;
      chk("rsp_dropped", 32'(bus.rsp_valid), 0);
    end
  endtask

  task automatic do_reset();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    sb.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    RST           = 1'b1;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.rsp_ready = 1'b0;
    tick(2);
    chk("rst_req_ready", 32'(bus.req_ready), 0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("rst_rsp_id", 32'(bus.rsp_id), 0);
    chk("rst_rsp_data", 32'(bus.rsp_data), 0);
    chk("rst_rsp_err", 32'(bus.rsp_err), 0);
    chk("rst_sqrt_in_valid", 32'(sqrt_in_valid), 0);
    chk("rst_sqrt_in", 32'(sqrt_in), 0);
    RST = 1'b0;

    // Single request on port 0
    set_req(0, 16'd1024);
    grant(0, 16'd1024);
    chk("issue_const", 32'(sqrt_in), 32'h0400);
    tick();
    chk("issue_one_cycle", 32'(sqrt_in_valid), 0);
    chk("sqrt_in_idle_zero", 32'(sqrt_in), 0);
    wait_rsp(40);

    // All four ports, then port 0 again after port 3
    do_reset();
    set_req(0, 16'd4);
    set_req(1, 16'd9);
    set_req(2, 16'd16);
    set_req(3, 16'd25);
    grant(0, 16'd4);
    wait_rsp(40);
    set_req(0, 16'd36);
    grant(1, 16'd9);
    wait_rsp(40);
    grant(2, 16'd16);
    wait_rsp(40);
    grant(3, 16'd25);
    wait_rsp(40);
    grant(0, 16'd36);
    wait_rsp(40);

    // Backpressure with port 2 waiting
    set_req(1, 16'd100);
    set_req(2, 16'd49);
    grant(1, 16'd100);
    cnt = 0;
    while (!bus.rsp_valid && cnt < 40) begin
      tick();
      cnt++;
    end
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", 32'(bus.rsp_valid), 1);
      chk("bp_id", 32'(bus.rsp_id), 1);
      chk("bp_data", 32'(bus.rsp_data), 32'(root84(16'd100)));
      chk("bp_no_ready", 32'(bus.req_ready), 0);
      chk("bp_no_issue", 32'(sqrt_in_valid), 0);
      tick();
    end
    wait_rsp(2);
    grant(2, 16'd49);
    wait_rsp(40);

    // Reset during WAIT; stale engine pulse must be ignored
    set_req(3, 16'd64);
    grant(3, 16'd64);
    tick(5);
    do_reset();
    chk("wrst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("wrst_rsp_id", 32'(bus.rsp_id), 0);
    chk("wrst_rsp_data", 32'(bus.rsp_data), 0);
    chk("wrst_sqrt_in_valid", 32'(sqrt_in_valid), 0);
    chk("wrst_req_ready", 32'(bus.req_ready), 0);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.rsp_valid) cnt++;
      tick();
    end
    chk("wrst_stale_ignored", 32'(cnt), 0);
    // With the pointer back at 0, port 2 beats port 3
    set_req(2, 16'd49);
    set_req(3, 16'd64);
    grant(2, 16'd49);
    wait_rsp(40);
    grant(3, 16'd64);
    wait_rsp(40);

    // Spurious engine pulses in IDLE and during ISSUE
    spur_data  = 12'hABC;
    spur_valid = 1'b1;
    tick();
    spur_valid = 1'b0;
    chk("spur_idle_a", 32'(bus.rsp_valid), 0);
    tick();
    chk("spur_idle_b", 32'(bus.rsp_valid), 0);
    set_req(1, 16'd144);
    grant(1, 16'd144);
    spur_valid = 1'b1;
    tick();
    spur_valid = 1'b0;
    wait_rsp(40);

    // Engine never answers
    model_on = 1'b0;
    set_req(0, 16'd1);
    grant(0, 16'd1);
    tick();
`ifdef SQRT_SCHED_TIMEOUT_EN
    cnt = 0;
    while (!bus.rsp_valid && cnt < 100) begin
      tick();
      cnt++;
    end
    chk("timeout_latency", 32'(cnt), TIMEOUT);
    void'(sb.pop_back());
    sb.push_back('{err: 1'b1, id: '0, data: '0});
    wait_rsp(2);
`else
    cnt = 0;
    for (int i = 0; i < 200; i++) begin
      if (bus.rsp_valid) cnt++;
      tick();
    end
    chk("no_timeout_wait", 32'(cnt), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
